gcn_operand_server: RTL and testbench

Memory-side responder for the GCN accelerator's operand read interface. It is loaded once by a host through a valid/ready word stream with the weight matrix, the feature matrix and the 2×6 COO edge list. It then serves the accelerator's `read_address`/`enable_read` requests with full 96-element rows on `data_in`, and its `coo_address` requests with edge pairs on `coo_in`. It also issues the accelerator's `start` pulse once the load is complete.

---
 rtl/gcn_operand_server.sv | 168 ++++++++++++++++
 tb/tb_gcn_operand_server.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcn_operand_server.sv
// Operand server for the GCN accelerator: loaded once over a valid/ready word stream,
// then returns weight columns, feature rows and COO edge pairs with one-cycle latency.
module gcn_operand_server #(
    parameter int WEIGHT_ROWS     = 96,
    parameter int WEIGHT_COLS     = 3,
    parameter int FEATURE_ROWS    = 6,
    parameter int WEIGHT_WIDTH    = 5,
    parameter int ADDRESS_WIDTH   = 13,
    parameter int FEATURE_BASE    = 512,
    parameter int COO_NUM_OF_COLS = 6,
    parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     load_start,
    input  logic                                     load_valid,
    input  logic [WEIGHT_WIDTH-1:0]                  load_data,
    output logic                                     load_ready,
    output logic                                     ready,
    output logic                                     start,
    input  logic                                     enable_read,
    input  logic [ADDRESS_WIDTH-1:0]                 read_address,
    output logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] data_in,
    input  logic [COO_BW-1:0]                        coo_address,
    output logic [1:0][COO_BW-1:0]                   coo_in,
    output logic                                     addr_error
);
    localparam int EW  = $clog2(WEIGHT_ROWS);
    localparam int CAW = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
    localparam int FAW = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
    localparam int RW  = (CAW > FAW) ? CAW : FAW;
    localparam int CLW = COO_BW + 1;

    typedef enum logic [2:0] {
        IDLE, LOAD_WM, LOAD_FM, LOAD_COO, COMMIT, READY
    } state_t;

    state_t state, state_next;

    logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] wm  [WEIGHT_COLS];
    logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] fm  [FEATURE_ROWS];
    logic [COO_BW-1:0]                        coo [2][COO_NUM_OF_COLS];

    logic [EW-1:0]            elem_idx;
    logic [RW-1:0]            row_idx;
    logic                     xfer, accept_start, elem_last, row_last, phase_done;
    logic [ADDRESS_WIDTH-1:0] fm_offset;
    logic                     is_wm, is_fm, coo_ok, serving;

    assign load_ready   = (state == LOAD_WM) || (state == LOAD_FM) || (state == LOAD_COO);
    assign ready        = (state == READY);
    assign serving      = (state == READY);
    assign xfer         = load_valid && load_ready;
    assign accept_start = load_start && ((state == IDLE) || (state == READY));

    // NOTE: every variable driven here gets a default first so no path can infer a latch.
    always_comb begin
        elem_last = 1'b0;
        row_last  = 1'b0;
        case (state)
            LOAD_WM: begin
                elem_last = (elem_idx == EW'(WEIGHT_ROWS - 1));
                row_last  = (row_idx == RW'(WEIGHT_COLS - 1));
            end
            LOAD_FM: begin
                elem_last = (elem_idx == EW'(WEIGHT_ROWS - 1));
                row_last  = (row_idx == RW'(FEATURE_ROWS - 1));
            end
            LOAD_COO: begin
                elem_last = (elem_idx == EW'(COO_NUM_OF_COLS - 1));
                row_last  = (row_idx == RW'(1));
            end
            default: ;
        endcase
    end

    assign phase_done = xfer && elem_last && row_last;

    always_comb begin
        state_next = state;
        case (state)
            IDLE, READY: if (load_start) state_next = LOAD_WM;
            LOAD_WM:     if (phase_done) state_next = LOAD_FM;
            LOAD_FM:     if (phase_done) state_next = LOAD_COO;
            LOAD_COO:    if (phase_done) state_next = COMMIT;
            COMMIT:      state_next = READY;
            default:     state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elem_idx <= '0;
            row_idx  <= '0;
        end else if (accept_start) begin
            elem_idx <= '0;
            row_idx  <= '0;
        end else if (xfer) begin
            if (elem_last) begin
                elem_idx <= '0;
                row_idx  <= row_last ? '0 : row_idx + RW'(1);
            end else begin
                elem_idx <= elem_idx + EW'(1);
            end
        end
    end

    // NOTE: storage is built from resettable flops, not RAM, because reset must clear contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < WEIGHT_COLS; c++)  wm[c] <= '0;
            for (int i = 0; i < FEATURE_ROWS; i++) fm[i] <= '0;
            for (int r = 0; r < 2; r++)
                for (int e = 0; e < COO_NUM_OF_COLS; e++) coo[r][e] <= '0;
        end else if (xfer) begin
            case (state)
                LOAD_WM:  wm[row_idx[CAW-1:0]][elem_idx] <= load_data;
                LOAD_FM:  fm[row_idx[FAW-1:0]][elem_idx] <= load_data;
                LOAD_COO: coo[row_idx[0]][elem_idx[COO_BW-1:0]] <= load_data[COO_BW-1:0];
                default: ;
            endcase
        end
    end

    assign fm_offset = read_address - ADDRESS_WIDTH'(FEATURE_BASE);
    assign is_wm     = read_address < ADDRESS_WIDTH'(WEIGHT_COLS);
    assign is_fm     = (read_address >= ADDRESS_WIDTH'(FEATURE_BASE))
                    && (fm_offset < ADDRESS_WIDTH'(FEATURE_ROWS));
    assign coo_ok    = CLW'(coo_address) < CLW'(COO_NUM_OF_COLS);

    // A same-cycle illegal access outranks the clear from an accepted load_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_in    <= '0;
            coo_in     <= '0;
            addr_error <= 1'b0;
            start      <= 1'b0;
        end else begin
            start <= (state == COMMIT);
            if (accept_start) addr_error <= 1'b0;

            if (enable_read) begin
                if (serving && is_wm) begin
                    data_in <= wm[read_address[CAW-1:0]];
                end else if (serving && is_fm) begin
                    data_in <= fm[fm_offset[FAW-1:0]];
                end else begin
                    data_in    <= '0;
                    addr_error <= 1'b1;
                end
            end

            if (serving && coo_ok) begin
                coo_in <= {coo[1][coo_address], coo[0][coo_address]};
            end else begin
                coo_in <= '0;
                if (serving) addr_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gcn_operand_server.sv
// Bench for gcn_operand_server: directed loads plus randomized contents and load_valid
// gaps, checked against an array model of the operand matrices and edge list.
module tb_gcn_operand_server;
    localparam int ROWS    = 96;
    localparam int COLS    = 3;
    localparam int FROWS   = 6;
    localparam int W       = 5;
    localparam int AW      = 13;
    localparam int FBASE   = 512;
    localparam int NE      = 6;
    localparam int CBW     = 3;
    localparam int DW      = ROWS * W;
    localparam int N_WM    = ROWS * COLS;
    localparam int N_FM    = ROWS * FROWS;
    localparam int N_TOTAL = N_WM + N_FM + 2 * NE;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           load_start = 1'b0;
    logic           load_valid = 1'b0;
    logic [W-1:0]   load_data = '0;
    logic           enable_read = 1'b0;
    logic [AW-1:0]  read_address = '0;
    logic [CBW-1:0] coo_address = '0;
    logic           load_ready, ready, start, addr_error;
    logic [DW-1:0]  data_in;
    logic [2*CBW-1:0] coo_in;

    int n_cmp = 0;
    int n_bad = 0;

    int m_wm  [COLS][ROWS];
    int m_fm  [FROWS][ROWS];
    int m_coo [2][NE];

    int b2b_addr [5] = '{0, 1, 2, 512, 517};
    int b2b_e5   [5] = '{5, 6, 7, 5, 20};

    gcn_operand_server dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .ready        (ready),
        .start        (start),
        .enable_read  (enable_read),
        .read_address (read_address),
        .data_in      (data_in),
        .coo_address  (coo_address),
        .coo_in       (coo_in),
        .addr_error   (addr_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_plan();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) m_wm[c][r] = (c + r) % 32;
        for (int i = 0; i < FROWS; i++)
            for (int r = 0; r < ROWS; r++) m_fm[i][r] = (i * 3 + r) % 32;
        for (int e = 0; e < NE; e++) begin
            m_coo[0][e] = e;
            m_coo[1][e] = (e + 1) % NE;
        end
    endtask

    task automatic fill_random();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) m_wm[c][r] = int'($urandom_range(0, 31));
        for (int i = 0; i < FROWS; i++)
            for (int r = 0; r < ROWS; r++) m_fm[i][r] = int'($urandom_range(0, 31));
        for (int e = 0; e < NE; e++) begin
            m_coo[0][e] = int'($urandom_range(0, NE - 1));
            m_coo[1][e] = int'($urandom_range(0, NE - 1));
        end
    endtask

    // Load stream order: weights column-major, features row-major, then COO row 0 and row 1.
    function automatic logic [W-1:0] word_at(input int k);
        int j;
        if (k < N_WM) return W'(m_wm[k / ROWS][k % ROWS]);
        if (k < N_WM + N_FM) begin
            j = k - N_WM;
            return W'(m_fm[j / ROWS][j % ROWS]);
        end
        j = k - N_WM - N_FM;
        return W'(m_coo[j / NE][j % NE]);
    endfunction

    function automatic logic [DW-1:0] exp_row(input int addr);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (addr < COLS) r[i*W +: W] = W'(m_wm[addr][i]);
            else if (addr >= FBASE && addr < FBASE + FROWS) r[i*W +: W] = W'(m_fm[addr - FBASE][i]);
        end
        return r;
    endfunction

    function automatic logic [2*CBW-1:0] exp_pair(input int a);
        if (a < NE) return {CBW'(m_coo[1][a]), CBW'(m_coo[0][a])};
        return '0;
    endfunction

    task automatic load_all(input string tag, input bit rand_valid, input int start_at);
        int k;
        int cyc;
        int budget;
        k = 0;
        cyc = 0;
        budget = 0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check($sformatf("%s_load_ready_up", tag), DW'(load_ready), DW'(1));
        check($sformatf("%s_err_cleared", tag), DW'(addr_error), DW'(0));
        while (k < N_TOTAL && cyc < 20000) begin
            load_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            load_data  = word_at(k);
            load_start = (k == start_at);
            step();
            cyc++;
            load_start = 1'b0;
            if (load_valid) k++;
        end
        load_valid = 1'b0;
        check($sformatf("%s_words_sent", tag), DW'(k), DW'(N_TOTAL));
        check($sformatf("%s_not_ready_at_last_word", tag), DW'({ready, start}), DW'(0));
        while (!ready && budget < 8) begin
            step();
            cyc++;
            budget++;
        end
        check($sformatf("%s_ready_up", tag), DW'(ready), DW'(1));
        check($sformatf("%s_start_pulse", tag), DW'(start), DW'(1));
        check($sformatf("%s_load_ready_low", tag), DW'(load_ready), DW'(0));
        if (!rand_valid) check($sformatf("%s_cycles_to_ready", tag), DW'(cyc), DW'(N_TOTAL + 1));
        step();
        check($sformatf("%s_start_one_cycle", tag), DW'({ready, start}), DW'(2));
    endtask

    task automatic verify_all(input string tag);
        int last;
        last = 0;
        enable_read = 1'b1;
        for (int a = 0; a < COLS + FROWS; a++) begin
            last = (a < COLS) ? a : FBASE + a - COLS;
            read_address = AW'(last);
            step();
            check($sformatf("%s_row_%0d", tag, last), data_in, exp_row(last));
        end
        enable_read = 1'b0;
        read_address = '0;
        step();
        check($sformatf("%s_hold", tag), data_in, exp_row(last));
        for (int a = 0; a < NE; a++) begin
            coo_address = CBW'(a);
            step();
            check($sformatf("%s_coo_%0d", tag, a), DW'(coo_in), DW'(exp_pair(a)));
        end
        coo_address = '0;
        check($sformatf("%s_no_err", tag), DW'(addr_error), DW'(0));
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        check("rst_load_ready", DW'(load_ready), DW'(0));
        check("rst_ready_start", DW'({ready, start}), DW'(0));
        check("rst_addr_error", DW'(addr_error), DW'(0));
        check("rst_data_in", data_in, DW'(0));
        check("rst_coo_in", DW'(coo_in), DW'(0));
        step();
        step();
        reset = 1'b0;
        step();
        check("idle_load_ready", DW'(load_ready), DW'(0));

        // Test-plan contents with load_valid held high.
        fill_plan();
        load_all("plan", 1'b0, -1);

        enable_read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            read_address = AW'(b2b_addr[i]);
            step();
            check($sformatf("b2b_e5_%0d", b2b_addr[i]), DW'(data_in[5*W +: W]), DW'(b2b_e5[i]));
            check($sformatf("b2b_row_%0d", b2b_addr[i]), data_in, exp_row(b2b_addr[i]));
        end
        enable_read = 1'b0;
        step();
        check("b2b_hold", data_in, exp_row(517));
        check("b2b_no_err", DW'(addr_error), DW'(0));

        enable_read = 1'b1;
        read_address = AW'(3);
        step();
        check("bad3_zero", data_in, DW'(0));
        check("bad3_err", DW'(addr_error), DW'(1));
        read_address = AW'(FBASE - 1);
        step();
        check("bad511_zero", data_in, DW'(0));
        read_address = AW'(518);
        step();
        check("bad518_zero", data_in, DW'(0));
        read_address = AW'(1);
        step();
        check("after_bad_row_1", data_in, exp_row(1));
        check("err_sticky", DW'(addr_error), DW'(1));
        enable_read = 1'b0;

        for (int a = 0; a < NE; a++) begin
            coo_address = CBW'(a);
            step();
            check($sformatf("plan_coo_%0d", a), DW'(coo_in), DW'(exp_pair(a)));
        end
        coo_address = CBW'(6);
        step();
        check("coo6_zero", DW'(coo_in), DW'(0));
        check("coo6_err", DW'(addr_error), DW'(1));
        coo_address = '0;
        step();
        check("coo_recover", DW'(coo_in), DW'(exp_pair(0)));

        // Random contents, random load_valid gaps, stray load_start during LOAD_FM.
        fill_random();
        load_all("rand", 1'b1, 400);
        verify_all("rand");

        // Abort a load at word 400 with an asynchronous reset.
        fill_plan();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1;
        for (int k = 0; k < 400; k++) begin
            load_data = word_at(k);
            step();
        end
        check("abort_midload_ready", DW'(load_ready), DW'(1));
        reset = 1'b1;
        #1;
        load_valid = 1'b0;
        check("abort_load_ready", DW'(load_ready), DW'(0));
        check("abort_ready_start", DW'({ready, start}), DW'(0));
        check("abort_data_in", data_in, DW'(0));
        check("abort_coo_err", DW'({coo_in, addr_error}), DW'(0));
        step();
        reset = 1'b0;
        step();
        check("abort_idle", DW'(load_ready), DW'(0));

        enable_read = 1'b1;
        read_address = '0;
        step();
        check("idle_read_zero", data_in, DW'(0));
        check("idle_read_err", DW'(addr_error), DW'(1));
        enable_read = 1'b0;

        load_all("reload", 1'b0, -1);
        verify_all("reload");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
